// File: rtl/vc_tx_port.sv
// Transmit side of a two-VC router link: per-VC FIFOs, credit-based flow control and a
// round-robin arbiter driving one registered flit per cycle towards the downstream buffer.
module vc_tx_port #(
  parameter int unsigned FLIT_W  = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CREDITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_vc,
  input  logic              in_valid,
  output logic              in_ready0,
  output logic              in_ready1,
  input  logic              credit_ret0,
  input  logic              credit_ret1,
  output logic [FLIT_W-1:0] flit_out,
  output logic [1:0]        vc_sel,
  output logic              flit_valid,
  output logic              credit_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned CrdW = $clog2(CREDITS) + 1;
  localparam logic [CntW-1:0] DepthC   = CntW'(DEPTH);
  localparam logic [CrdW-1:0] CreditsC = CrdW'(CREDITS);
  localparam logic [1:0]      VcIdle   = 2'b11;

  logic [FLIT_W-1:0]        mem_q [2][DEPTH];
  logic [1:0][PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [1:0][PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [1:0][CntW-1:0]     count_q, count_d;
  logic [1:0][CrdW-1:0]     credit_q, credit_d;
  logic                     rr_last_q, rr_last_d;
  logic                     credit_err_q, credit_err_d;
  logic [FLIT_W-1:0]        flit_out_q, flit_out_d;
  logic [1:0]               vc_sel_q, vc_sel_d;
  logic                     flit_valid_q, flit_valid_d;

  logic [1:0]               in_ready;
  logic [1:0]               push;
  logic [1:0]               pop;
  logic [1:0]               elig;
  logic [1:0]               ret;
  logic                     gnt_valid;
  logic                     gnt_vc;
  logic [FLIT_W-1:0]        head;

  assign in_ready  = {count_q[1] != DepthC, count_q[0] != DepthC};
  assign in_ready0 = in_ready[0];
  assign in_ready1 = in_ready[1];
  assign ret       = {credit_ret1, credit_ret0};

  // A zero flit is the idle encoding on the link, so it is never queued.
  always_comb begin
    push[0] = in_valid & ~in_vc & in_ready[0] & (in_flit != '0);
    push[1] = in_valid &  in_vc & in_ready[1] & (in_flit != '0);
  end

  always_comb begin
    for (int v = 0; v < 2; v++) begin
      elig[v] = (count_q[v] != '0) && (credit_q[v] != '0);
    end
  end

  // Round-robin: on a tie the VC that was not granted last wins.
  always_comb begin
    gnt_valid = |elig;
    gnt_vc    = 1'b0;
    case (elig)
      2'b01:   gnt_vc = 1'b0;
      2'b10:   gnt_vc = 1'b1;
      2'b11:   gnt_vc = ~rr_last_q;
      default: gnt_vc = 1'b0;
    endcase
    pop[0]    = gnt_valid & ~gnt_vc;
    pop[1]    = gnt_valid &  gnt_vc;
    rr_last_d = gnt_valid ? gnt_vc : rr_last_q;
  end

  always_comb begin
    credit_err_d = credit_err_q;
    for (int v = 0; v < 2; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v] + PtrW'(push[v]);
      rd_ptr_d[v] = rd_ptr_q[v] + PtrW'(pop[v]);

      count_d[v] = count_q[v];
      case ({push[v], pop[v]})
        2'b10:   count_d[v] = count_q[v] + CntW'(1);
        2'b01:   count_d[v] = count_q[v] - CntW'(1);
        default: count_d[v] = count_q[v];
      endcase

      // A return that coincides with a grant cancels it out; a lone return at full credit
      // means the downstream side returned more than it was given.
      credit_d[v] = credit_q[v];
      case ({pop[v], ret[v]})
        2'b10: credit_d[v] = credit_q[v] - CrdW'(1);
        2'b01: begin
          if (credit_q[v] == CreditsC) begin
            credit_err_d = 1'b1;
          end else begin
            credit_d[v] = credit_q[v] + CrdW'(1);
          end
        end
        default: credit_d[v] = credit_q[v];
      endcase
    end
  end

  always_comb begin
    head         = mem_q[gnt_vc][rd_ptr_q[gnt_vc]];
    flit_out_d   = gnt_valid ? head : '0;
    vc_sel_d     = gnt_valid ? {1'b0, gnt_vc} : VcIdle;
    flit_valid_d = gnt_valid;
  end

  // Storage needs no reset: entries are only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (push[0]) mem_q[0][wr_ptr_q[0]] <= in_flit;
    if (push[1]) mem_q[1][wr_ptr_q[1]] <= in_flit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      credit_q     <= {CreditsC, CreditsC};
      rr_last_q    <= 1'b1;
      credit_err_q <= 1'b0;
      flit_out_q   <= '0;
      vc_sel_q     <= VcIdle;
      flit_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      credit_q     <= credit_d;
      rr_last_q    <= rr_last_d;
      credit_err_q <= credit_err_d;
      flit_out_q   <= flit_out_d;
      vc_sel_q     <= vc_sel_d;
      flit_valid_q <= flit_valid_d;
    end
  end

  assign flit_out   = flit_out_q;
  assign vc_sel     = vc_sel_q;
  assign flit_valid = flit_valid_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_vc_tx_port.sv
// Bench for vc_tx_port: directed stimulus with an expected-flit queue checked by an output
// monitor, plus point checks on reset, latency, credit stalls and error reporting.
module tb_vc_tx_port;

  logic       clk;
  logic       rst;
  logic [7:0] in_flit;
  logic       in_vc;
  logic       in_valid;
  logic       in_ready0;
  logic       in_ready1;
  logic       credit_ret0;
  logic       credit_ret1;
  logic [7:0] flit_out;
  logic [1:0] vc_sel;
  logic       flit_valid;
  logic       credit_err;

  typedef struct packed {
    logic [1:0] vc;
    logic [7:0] flit;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  vc_tx_port #(
    .FLIT_W  (8),
    .DEPTH   (4),
    .CREDITS (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_flit     (in_flit),
    .in_vc       (in_vc),
    .in_valid    (in_valid),
    .in_ready0   (in_ready0),
    .in_ready1   (in_ready1),
    .credit_ret0 (credit_ret0),
    .credit_ret1 (credit_ret1),
    .flit_out    (flit_out),
    .vc_sel      (vc_sel),
    .flit_valid  (flit_valid),
    .credit_err  (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Every output flit must match the head of the expected queue; idle cycles must be clean.
  always @(negedge clk) begin
    if (flit_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_flit", {22'd0, vc_sel, flit_out}, 32'h3ff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("flit_data", {24'd0, flit_out}, {24'd0, e.flit});
        check("flit_vc", {30'd0, vc_sel}, {30'd0, e.vc});
      end
    end else begin
      check("idle_flit", {24'd0, flit_out}, 32'd0);
      check("idle_vc", {30'd0, vc_sel}, 32'd3);
    end
  end

  task automatic expect_flit(input logic vc, input logic [7:0] f);
    exp_t e;
    e.vc   = {1'b0, vc};
    e.flit = f;
    exp_q.push_back(e);
  endtask

  task automatic push_flit(input logic vc, input logic [7:0] f);
    in_vc    = vc;
    in_flit  = f;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_flit  = 8'h00;
  endtask

  task automatic ret(input logic [1:0] m);
    credit_ret0 = m[0];
    credit_ret1 = m[1];
    @(posedge clk); #1;
    credit_ret0 = 1'b0;
    credit_ret1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic check_idle_regs(input string tag);
    check({tag, "_flit_out"}, {24'd0, flit_out}, 32'd0);
    check({tag, "_vc_sel"}, {30'd0, vc_sel}, 32'd3);
    check({tag, "_flit_valid"}, {31'd0, flit_valid}, 32'd0);
    check({tag, "_in_ready0"}, {31'd0, in_ready0}, 32'd1);
    check({tag, "_in_ready1"}, {31'd0, in_ready1}, 32'd1);
  endtask

  initial begin
    in_flit     = 8'h00;
    in_vc       = 1'b0;
    in_valid    = 1'b0;
    credit_ret0 = 1'b0;
    credit_ret1 = 1'b0;
    rst         = 1'b1;

    // Reset asserted between clock edges must take effect immediately.
    #2 rst = 1'b0;
    #1;
    check_idle_regs("reset");
    check("reset_credit_err", {31'd0, credit_err}, 32'd0);
    #20 rst = 1'b1;
    @(posedge clk); #1;

    // Single flit: one cycle of latency, then VC0 waits for its credit.
    expect_flit(1'b0, 8'hA5);
    push_flit(1'b0, 8'hA5);
    check("no_bypass", {31'd0, flit_valid}, 32'd0);
    @(posedge clk); #1;
    check("single_flit", {24'd0, flit_out}, 32'hA5);
    check("single_vc", {30'd0, vc_sel}, 32'd0);
    push_flit(1'b0, 8'hA6);
    idle(3);
    check("vc0_blocked", {31'd0, flit_valid}, 32'd0);
    expect_flit(1'b0, 8'hA6);
    ret(2'b01);
    wait_drain(10);
    ret(2'b01);

    // Credit stall on VC1.
    expect_flit(1'b1, 8'hA1);
    push_flit(1'b1, 8'hA1);
    push_flit(1'b1, 8'hA2);
    wait_drain(10);
    idle(3);
    check("stall_vc_sel", {30'd0, vc_sel}, 32'd3);
    expect_flit(1'b1, 8'hA2);
    ret(2'b10);
    @(posedge clk); #1;
    check("stall_release_flit", {24'd0, flit_out}, 32'hA2);
    check("stall_release_vc", {30'd0, vc_sel}, 32'd1);
    wait_drain(10);
    ret(2'b10);

    // Round-robin: drain both credits, preload both VCs, then release credits together.
    expect_flit(1'b0, 8'h0F);
    expect_flit(1'b1, 8'h1F);
    push_flit(1'b0, 8'h0F);
    push_flit(1'b1, 8'h1F);
    wait_drain(10);
    push_flit(1'b0, 8'h11);
    push_flit(1'b0, 8'h12);
    push_flit(1'b1, 8'h21);
    push_flit(1'b1, 8'h22);
    expect_flit(1'b0, 8'h11);
    expect_flit(1'b1, 8'h21);
    ret(2'b11);
    wait_drain(10);
    expect_flit(1'b0, 8'h12);
    expect_flit(1'b1, 8'h22);
    ret(2'b11);
    wait_drain(10);
    ret(2'b11);

    // Fill VC0 with no credit, overflow it, then drain across the pointer wrap.
    expect_flit(1'b0, 8'h0E);
    push_flit(1'b0, 8'h0E);
    wait_drain(10);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) check("full_ready0", {31'd0, in_ready0}, 32'd0);
      push_flit(1'b0, 8'hB1 + 8'(i));
    end
    check("full_ready0_after", {31'd0, in_ready0}, 32'd0);
    check("full_ready1", {31'd0, in_ready1}, 32'd1);
    for (int i = 0; i < 4; i++) expect_flit(1'b0, 8'hB1 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      ret(2'b01);
      @(posedge clk); #1;
      if (i == 0) check("ready0_after_pop", {31'd0, in_ready0}, 32'd1);
    end
    wait_drain(10);
    ret(2'b01);

    // Zero flit is never queued.
    push_flit(1'b0, 8'h00);
    idle(4);
    check("zero_flit_ignored", {31'd0, flit_valid}, 32'd0);

    // Return at full credit: error flag, counter must not grow past one.
    check("credit_err_before", {31'd0, credit_err}, 32'd0);
    ret(2'b01);
    check("credit_err_set", {31'd0, credit_err}, 32'd1);
    expect_flit(1'b0, 8'hC1);
    push_flit(1'b0, 8'hC1);
    push_flit(1'b0, 8'hC2);
    wait_drain(10);
    idle(3);
    check("credit_not_overflowed", {31'd0, flit_valid}, 32'd0);
    check("credit_err_sticky", {31'd0, credit_err}, 32'd1);
    expect_flit(1'b0, 8'hC2);
    ret(2'b01);
    wait_drain(10);

    // Reset with queued flits: nothing comes out afterwards, credits restored.
    push_flit(1'b0, 8'hD1);
    push_flit(1'b0, 8'hD2);
    #2 rst = 1'b0;
    #1;
    check_idle_regs("midreset");
    check("midreset_credit_err", {31'd0, credit_err}, 32'd0);
    #10 rst = 1'b1;
    @(posedge clk); #1;
    idle(5);
    check("post_reset_silent", {31'd0, flit_valid}, 32'd0);
    expect_flit(1'b0, 8'hE1);
    push_flit(1'b0, 8'hE1);
    wait_drain(10);
    idle(2);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
